// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a registered-output sync FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  baud_last;

    // Next-state logic, FIFO read strobe and end-of-frame pulse.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        tx_done   = 1'b0;
        baud_last = (baud_q == CNT_LAST);
        // Gated by rst_n so no pop can be requested while reset is held.
        fifo_r_en = rst_n && (state_q == IDLE) && tx_enable && !fifo_empty;

        if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
            baud_d = baud_last ? '0 : baud_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_r_en) state_d = LOAD;
            end
            LOAD: begin
                // FIFO output is valid the cycle after the read strobe.
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                tx_d     = 1'b0;
                baud_d   = '0;
                idx_d    = '0;
                state_d  = START;
            end
            START: begin
                if (baud_last) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; tx comes straight from a flop so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain, even parity, two stop bits), each fed by a
// small FIFO model; expected bytes are queued on write and compared when a frame is decoded.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ten = 3'b000;
    logic [2:0] fe = 3'b111;
    logic [2:0] wr_en = 3'b000;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fd [3] = '{8'h00, 8'h00, 8'h00};
    logic [2:0] ren, txw, busyw, donew;

    logic [7:0] mem [3][16];
    int wp [3] = '{0, 0, 0};
    int rp [3] = '{0, 0, 0};
    int cnt [3] = '{0, 0, 0};
    int ren_cnt [3] = '{0, 0, 0};
    int busy_cnt [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int bad_pop = 0;
    int viol = 0;

    exp_t sb [$];
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_enable(ten[0]), .fifo_empty(fe[0]), .fifo_data(fd[0]),
        .fifo_r_en(ren[0]), .tx(txw[0]), .busy(busyw[0]), .tx_done(donew[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_enable(ten[1]), .fifo_empty(fe[1]), .fifo_data(fd[1]),
        .fifo_r_en(ren[1]), .tx(txw[1]), .busy(busyw[1]), .tx_done(donew[1]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_enable(ten[2]), .fifo_empty(fe[2]), .fifo_data(fd[2]),
        .fifo_r_en(ren[2]), .tx(txw[2]), .busy(busyw[2]), .tx_done(donew[2]));

    // FIFO models (registered data/empty, unaffected by DUT reset) plus activity counters.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ren[d]) begin
                ren_cnt[d]++;
                if (busyw[d]) viol++;
                if (cnt[d] == 0) begin
                    bad_pop++;
                end else begin
                    fd[d] <= mem[d][rp[d]];
                    rp[d] = (rp[d] + 1) % 16;
                    cnt[d]--;
                end
            end
            if (wr_en[d]) begin
                mem[d][wp[d]] = wr_data;
                wp[d] = (wp[d] + 1) % 16;
                cnt[d]++;
            end
            fe[d] <= (cnt[d] == 0);
            if (busyw[d]) busy_cnt[d]++;
            if (donew[d]) done_cnt[d]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic fifo_write(input int d, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        wr_data   = b;
        wr_en[d]  = 1'b1;
        e.d       = d;
        e.b       = b;
        sb.push_back(e);
        @(negedge clk);
        wr_en[d]  = 1'b0;
    endtask

    // Waits (bounded) for a start bit, samples every cycle of the frame, then checks it
    // against the oldest scoreboard entry. waited = negedges until tx first seen low.
    task automatic get_frame(input int d, input int nstop, input bit par, output int waited);
        logic [15:0] got, want;
        int          nb, dseen;
        bit          stable, found;
        logic        v, dlast;
        exp_t        e;
        nb     = 1 + 8 + int'(par) + nstop;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 400) begin
            @(negedge clk);
            waited++;
            if (txw[d] == 1'b0) found = 1'b1;
        end
        check("start_seen", found, 1);
        if (!found) return;
        got    = '0;
        stable = 1'b1;
        dseen  = 0;
        dlast  = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                v = txw[d];
                if (c == 0) got[k] = v;
                else if (v !== got[k]) stable = 1'b0;
                if (donew[d]) dseen++;
                dlast = donew[d];
            end
        end
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        want = '0;
        for (int i = 0; i < 8; i++) want[1 + i] = e.b[i];
        if (par) want[9] = ^e.b;
        for (int s = 0; s < nstop; s++) want[9 + int'(par) + s] = 1'b1;
        check("frame_dut", d, e.d);
        check("frame_bits", got, want);
        if (par) check("parity_bit", got[9], ^e.b);
        check("bit_stable", stable, 1);
        check("done_last_cycle", dlast, 1);
        check("done_once", dseen, 1);
    endtask

    initial begin
        int w, r0, b0, d0;
        bit flag, found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", txw, 3'b111);
        check("rst_busy", busyw, 3'b000);
        check("rst_ren", ren, 3'b000);
        check("rst_done", donew, 3'b000);
        rst_n = 1'b1;

        // Basic 0xA5 frame
        fifo_write(0, 8'hA5);
        r0 = ren_cnt[0];
        b0 = busy_cnt[0];
        d0 = done_cnt[0];
        ten[0] = 1'b1;
        get_frame(0, 1, 1'b0, w);
        check("basic_latency", w, 2);
        repeat (2) @(negedge clk);
        check("basic_busy_cycles", busy_cnt[0] - b0, 41);
        check("basic_one_pop", ren_cnt[0] - r0, 1);
        check("basic_one_done", done_cnt[0] - d0, 1);

        // Empty FIFOs with enable high: nothing happens
        ten = 3'b111;
        r0 = ren_cnt[0] + ren_cnt[1] + ren_cnt[2];
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (txw !== 3'b111 || busyw !== 3'b000) flag = 1'b1;
        end
        check("empty_no_pop", ren_cnt[0] + ren_cnt[1] + ren_cnt[2] - r0, 0);
        check("empty_idle", flag, 0);

        // Non-empty FIFO with enable low, then mid-frame disable
        ten = 3'b000;
        r0 = ren_cnt[0];
        fifo_write(0, 8'h3C);
        fifo_write(0, 8'h55);
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) flag = 1'b1;
        end
        check("disabled_no_pop", ren_cnt[0] - r0, 0);
        check("disabled_idle", flag, 0);
        ten[0] = 1'b1;
        fork
            get_frame(0, 1, 1'b0, w);
            begin
                repeat (10) @(negedge clk);
                ten[0] = 1'b0;
            end
        join
        check("midoff_latency", w, 2);
        repeat (20) @(negedge clk);
        check("midoff_one_pop", ren_cnt[0] - r0, 1);
        check("midoff_idle", busyw[0], 0);
        ten[0] = 1'b1;
        get_frame(0, 1, 1'b0, w);
        check("resume_latency", w, 2);

        // Even parity: 0xA5 -> 0, 0x07 -> 1, back to back
        ten[1] = 1'b0;
        fifo_write(1, 8'hA5);
        fifo_write(1, 8'h07);
        b0 = busy_cnt[1];
        ten[1] = 1'b1;
        get_frame(1, 1, 1'b1, w);
        check("par_latency", w, 2);
        get_frame(1, 1, 1'b1, w);
        check("par_gap", w, 3);
        repeat (2) @(negedge clk);
        check("par_busy_cycles", busy_cnt[1] - b0, 90);

        // Eight back-to-back frames
        ten[0] = 1'b0;
        r0 = ren_cnt[0];
        for (int i = 1; i <= 8; i++) fifo_write(0, 8'(i));
        ten[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_frame(0, 1, 1'b0, w);
            if (i > 0) check("b2b_gap", w, 3);
        end
        repeat (20) @(negedge clk);
        check("b2b_pops", ren_cnt[0] - r0, 8);
        check("b2b_fifo_empty", fe[0], 1);

        // Two stop bits
        fifo_write(2, 8'h96);
        b0 = busy_cnt[2];
        ten[2] = 1'b1;
        get_frame(2, 2, 1'b0, w);
        check("stop2_latency", w, 2);
        repeat (2) @(negedge clk);
        check("stop2_busy_cycles", busy_cnt[2] - b0, 45);

        // Reset during data bit 3 of 0xA5 (bit 3 = 0); 0xC3 must follow intact
        ten[0] = 1'b0;
        fifo_write(0, 8'hA5);
        fifo_write(0, 8'hC3);
        ten[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (txw[0] == 1'b0) found = 1'b1;
        end
        check("rst_frame_started", found, 1);
        repeat (17) @(negedge clk);
        check("rst_pre_bit3", txw[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_tx", txw[0], 1);
        check("rst_async_busy", busyw[0], 0);
        check("rst_async_ren", ren[0], 0);
        repeat (3) @(negedge clk);
        check("rst_hold_ren", ren[0], 0);
        rst_n = 1'b1;
        void'(sb.pop_front());
        get_frame(0, 1, 1'b0, w);
        check("rst_after_latency", w, 2);

        repeat (10) @(negedge clk);
        check("no_empty_pop", bad_pop, 0);
        check("no_pop_while_busy", viol, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
